// File: rtl/multi_channel_memory_streamer.sv
// multi_channel_memory_streamer: streams NUM_CH shared-address ROM channels through a credit-limited FWFT buffer
module multi_channel_memory_streamer #(
   parameter int DATA_SIZE   = 64,
   parameter int NUM_CH      = 2,
   parameter int ADDR_WIDTH  = 14,
   parameter int MEM_LATENCY = 1,
   parameter int FIFO_DEPTH  = 4,
   parameter int PASS_WIDTH  = 16
) (
   input  logic                           i_clock,
   input  logic                           i_reset,
   input  logic                           i_start,
   input  logic                           i_stop,
   input  logic                           i_loop,
   input  logic [ADDR_WIDTH-1:0]          i_length,
   output logic                           o_mem_en,
   output logic [ADDR_WIDTH-1:0]          o_mem_addr,
   input  logic [NUM_CH*DATA_SIZE-1:0]    i_mem_data,
   output logic [NUM_CH*DATA_SIZE-1:0]    o_data,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic                           o_last,
   output logic                           o_busy,
   output logic                           o_done,
   output logic [PASS_WIDTH-1:0]          o_pass_count
);
   localparam int DW = NUM_CH * DATA_SIZE;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 2;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_addr, r_len;
   logic r_loop, r_done;
   logic [PASS_WIDTH-1:0] r_pass;
   logic r_vpipe [MEM_LATENCY];
   logic r_lpipe [MEM_LATENCY];
   logic [DW-1:0] r_mem [FIFO_DEPTH];
   logic r_mlast [FIFO_DEPTH];
   logic [PW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_count, w_inflight;
   logic w_valid, w_pop, w_push, w_issue, w_at_end, w_start;

   assign w_valid  = r_count != '0;
   assign w_pop    = w_valid & i_ready;
   assign w_push   = r_vpipe[MEM_LATENCY-1];
   assign w_at_end = r_addr == r_len - ADDR_WIDTH'(1);
   assign w_start  = i_start & (i_length != '0);
   // an issue needs a guaranteed FIFO slot once everything in flight has landed
   assign w_issue  = (r_state == RUN) & (w_inflight + r_count - CW'(w_pop) < CW'(FIFO_DEPTH));

   assign o_mem_addr   = r_addr;
   assign o_valid      = w_valid;
   assign o_data       = w_valid ? r_mem[r_rd] : '0;
   assign o_last       = w_valid & r_mlast[r_rd];
   assign o_done       = r_done;
   assign o_pass_count = r_pass;

   // number of reads whose data has not yet reached the FIFO
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < MEM_LATENCY; i++) w_inflight = w_inflight + CW'(r_vpipe[i]);
   end

   // state register
   always_ff @(posedge i_clock) r_state <= i_reset ? IDLE : w_next;

   // next-state: start only with nonzero length, stop or one-shot end drains, drain ends when empty
   always_comb begin
      w_next = (r_state == IDLE) ? (w_start ? RUN : IDLE) :
               (r_state == RUN)  ? ((i_stop | (w_issue & ~r_loop & w_at_end)) ? DRAIN : RUN) :
               ((w_inflight == '0) && !w_valid) ? IDLE : DRAIN;
   end

   // FSM outputs
   always_comb begin
      o_busy   = r_state != IDLE;
      o_mem_en = w_issue;
   end

   // address, run configuration, pass counter and done pulse
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_addr <= '0;
         r_len  <= '0;
         r_loop <= 1'b0;
         r_pass <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == DRAIN) & (w_next == IDLE);
         if (r_state == IDLE && w_start) begin
            r_addr <= '0;
            r_len  <= i_length;
            r_loop <= i_loop;
            r_pass <= '0;
         end else begin
            if (w_issue) r_addr <= w_at_end ? '0 : r_addr + ADDR_WIDTH'(1);
            if (w_pop && r_mlast[r_rd]) r_pass <= r_pass + PASS_WIDTH'(1);
         end
      end
   end

   // read-tag pipeline aligned with the ROM latency, carrying the last-of-pass flag
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < MEM_LATENCY; i++) begin
            r_vpipe[i] <= 1'b0;
            r_lpipe[i] <= 1'b0;
         end
      end else begin
         r_vpipe[0] <= w_issue;
         r_lpipe[0] <= w_issue & w_at_end;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            r_vpipe[i] <= r_vpipe[i-1];
            r_lpipe[i] <= r_lpipe[i-1];
         end
      end
   end

   // output FIFO: captures returning ROM data, head is presented directly
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr]   <= i_mem_data;
            r_mlast[r_wr] <= r_lpipe[MEM_LATENCY-1];
            r_wr          <= r_wr + PW'(1);
         end
         if (w_pop) r_rd <= r_rd + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: tb/tb_multi_channel_memory_streamer.sv
// tb_multi_channel_memory_streamer: transaction-level scoreboard plus directed scenarios for the streamer
module tb_multi_channel_memory_streamer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, stop, lp, ready;
   logic [13:0] len;
   logic en, valid, last, busy, done;
   logic [13:0] addr;
   logic [127:0] din, data;
   logic [15:0] pass;

   logic b_start, b_en, b_valid, b_last, b_busy, b_done;
   logic [13:0] b_addr;
   logic [127:0] b_din, b_data;
   logic [15:0] b_pass;

   function automatic logic [127:0] mk(input logic [13:0] a);
      mk = {32'd1, 18'd0, a, 32'd0, 18'd0, a};
   endfunction

   multi_channel_memory_streamer dut (
      .i_clock(clk), .i_reset(rst), .i_start(start), .i_stop(stop), .i_loop(lp), .i_length(len),
      .o_mem_en(en), .o_mem_addr(addr), .i_mem_data(din), .o_data(data), .o_valid(valid),
      .i_ready(ready), .o_last(last), .o_busy(busy), .o_done(done), .o_pass_count(pass)
   );

   multi_channel_memory_streamer #(.MEM_LATENCY(3), .FIFO_DEPTH(4)) dut_b (
      .i_clock(clk), .i_reset(rst), .i_start(b_start), .i_stop(1'b0), .i_loop(1'b0), .i_length(14'd6),
      .o_mem_en(b_en), .o_mem_addr(b_addr), .i_mem_data(b_din), .o_data(b_data), .o_valid(b_valid),
      .i_ready(1'b1), .o_last(b_last), .o_busy(b_busy), .o_done(b_done), .o_pass_count(b_pass)
   );

   // ROM models: word for channel c is {c, addr}
   logic [13:0] a1, b1, b2, b3;
   always @(posedge clk) begin
      a1 <= addr;
      b1 <= b_addr;
      b2 <= b1;
      b3 <= b2;
   end
   assign din   = mk(a1);
   assign b_din = mk(b3);

   int total = 0, bad = 0, issues = 0, pops = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {logic l; logic [13:0] a;} ent_t;
   ent_t q[$];
   ent_t e;
   logic [13:0] m_addr = '0, m_last = '0;
   logic m_loop = 1'b0, m_stop = 1'b1, prev_stall = 1'b0;
   logic [15:0] m_pass = '0;
   logic [127:0] prev_data = '0;

   // scoreboard: expected address stream, in-order delivery, pass count, stall stability, buffer bound
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         m_stop = 1'b1;
         m_pass = '0;
         prev_stall = 1'b0;
      end else begin
         chk("pass_count", pass, m_pass);
         if (prev_stall) begin
            chk("stall_valid", valid, 1);
            chk("stall_data", data, prev_data);
         end
         if (valid && q.size() == 0) chk("spurious_valid", valid, 0);
         else if (valid && ready) begin
            e = q.pop_front();
            chk("out_data", data, mk(e.a));
            chk("out_last", last, e.l);
            pops++;
            if (e.l) m_pass++;
         end
         if (en) begin
            chk("issue_allowed", m_stop, 0);
            if (!m_stop) begin
               chk("issue_addr", addr, m_addr);
               q.push_back(ent_t'({m_addr == m_last, m_addr}));
               issues++;
               if (!m_loop && m_addr == m_last) m_stop = 1'b1;
               m_addr = (m_addr == m_last) ? 14'd0 : m_addr + 14'd1;
            end
         end
         chk("occupancy", q.size() <= 4, 1);
         if (stop && busy) m_stop = 1'b1;
         if (start && !busy && len != 0) begin
            m_addr = '0;
            m_last = len - 14'd1;
            m_loop = lp;
            m_stop = 1'b0;
            m_pass = '0;
         end
         prev_stall = valid && !ready;
         prev_data = data;
      end
   end

   task automatic do_start(input logic l, input logic [13:0] n);
      lp = l;
      len = n;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 400) begin
         step();
         n++;
      end
      chk("done_seen", done, 1);
   endtask

   int n, m, k, bi, bp;

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; lp = 1'b0; ready = 1'b1; len = '0; b_start = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      chk("reset_ctrl", {en, addr, valid, last, busy, done, pass}, 0);
      chk("reset_data", data, 0);

      // zero length is ignored
      do_start(1'b0, 14'd0);
      chk("len0_busy", busy, 0);
      step();
      chk("len0_busy2", busy, 0);

      // one-shot length 5
      ready = 1'b1;
      do_start(1'b0, 14'd5);
      chk("t1_busy", busy, 1);
      n = 0;
      while (!valid && n < 20) begin step(); n++; end
      chk("t1_first_latency", n, 2);
      chk("t1_first_data", data, 128'h00000001000000000000000000000000);
      wait_done(m);
      chk("t1_done_time", n + m, 8);
      chk("t1_pass", pass, 1);
      chk("t1_busy_low", busy, 0);
      step();
      chk("t1_done_pulse", done, 0);

      // loop length 3, 12 samples then stop
      bp = pops;
      do_start(1'b1, 14'd3);
      n = 0;
      while (pops < bp + 12 && n < 100) begin step(); n++; end
      chk("t2_12_pops", pops - bp, 12);
      chk("t2_pass4", pass, 4);
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_done(m);
      chk("t2_idle", busy, 0);

      // backpressure 1,0,0 on one-shot length 8, with a start while busy
      do_start(1'b0, 14'd8);
      k = 0;
      while (!done && k < 200) begin
         ready = (k % 3 == 0);
         if (k == 5) begin start = 1'b1; len = 14'd3; lp = 1'b1; end
         else start = 1'b0;
         step();
         k++;
      end
      start = 1'b0;
      ready = 1'b1;
      chk("t3_done", done, 1);
      chk("t3_pass", pass, 1);

      // stop on the 10th issue of a long loop
      bi = issues;
      bp = pops;
      do_start(1'b1, 14'd100);
      n = 0;
      while (issues < bi + 9 && n < 50) begin step(); n++; end
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_done(m);
      chk("t4_issues", issues - bi, 10);
      chk("t4_pops", pops - bp, 10);
      chk("t4_pass", pass, 0);

      // reset with samples in flight
      ready = 1'b0;
      bi = issues;
      do_start(1'b1, 14'd100);
      n = 0;
      while (issues < bi + 3 && n < 20) begin step(); n++; end
      rst = 1'b1;
      step();
      chk("t5_rst_ctrl", {en, addr, valid, last, busy, done, pass}, 0);
      chk("t5_rst_data", data, 0);
      rst = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_no_stale", valid, 0);
      end
      bp = pops;
      do_start(1'b0, 14'd2);
      wait_done(m);
      chk("t5_pops", pops - bp, 2);
      chk("t5_pass", pass, 1);

      // latency-3 instance at full rate
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      n = 0;
      while (!b_valid && n < 20) begin step(); n++; end
      chk("b_first_latency", n, 4);
      for (int i = 0; i < 6; i++) begin
         chk("b_valid", b_valid, 1);
         chk("b_data", b_data, mk(14'(i)));
         chk("b_last", b_last, i == 5);
         step();
      end
      n = 0;
      while (!b_done && n < 20) begin step(); n++; end
      chk("b_done", b_done, 1);
      chk("b_pass", b_pass, 1);
      chk("b_busy", b_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multi_channel_memory_streamer.md
Name: multi_channel_memory_streamer

Overview:
Parametrised successor to the free-running two-ROM reader. It streams NUM_CH parallel sample channels (e.g. reference, error, auxiliary) from synchronous ROMs that share one address. Adds start/stop control, programmable length, one-shot/loop modes, a valid/ready output handshake, and latency-compensating buffering. It sits between the sample ROMs and the downstream processing pipeline.

Parameters:
DATA_SIZE, 64, width of one channel sample.
NUM_CH, 2, number of channels; all channels share the address.
ADDR_WIDTH, 14, ROM address width.
MEM_LATENCY, 1, cycles from o_mem_en/o_mem_addr to valid i_mem_data; legal range 1..4.
FIFO_DEPTH, 4, output buffer entries; must be >= MEM_LATENCY+1; power of two.
PASS_WIDTH, 16, width of the pass counter.

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  start pulse; sampled in IDLE only
i_stop  in  1  stop request; sampled in RUN only
i_loop  in  1  1 = loop mode, 0 = one-shot; latched on accepted start
i_length  in  ADDR_WIDTH  samples per pass; latched on accepted start
o_mem_en  out  1  ROM read enable
o_mem_addr  out  ADDR_WIDTH  ROM address
i_mem_data  in  NUM_CH*DATA_SIZE  ROM data; channel c at bits [c*DATA_SIZE +: DATA_SIZE]
o_data  out  NUM_CH*DATA_SIZE  output sample vector
o_valid  out  1  o_data valid
i_ready  in  1  downstream accepts
o_last  out  1  marks the sample for address length-1; qualified by o_valid
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse on return to IDLE
o_pass_count  out  PASS_WIDTH  completed passes since the last accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO emptied, in-flight pipeline cleared. In-flight ROM data is discarded, including when reset is asserted mid-operation.
- States: IDLE, RUN, DRAIN.
- IDLE->RUN: i_start=1 and i_length!=0. The block latches the length and mode, clears the address and o_pass_count, and sets o_busy the next cycle. i_start with i_length=0 is ignored. i_start outside IDLE is ignored.
- Issue rule in RUN: o_mem_en=1 when inflight + fifo_count - pop < FIFO_DEPTH, where pop = o_valid & i_ready in the same cycle. This guarantees no FIFO overflow.
- Throughput: with i_ready held at 1, one sample per cycle is issued.
- Addressing:
  - o_mem_addr increments on each issue, from 0 to length-1.
  - Loop mode: after length-1 the address wraps to 0 and issuing continues.
  - One-shot mode: after issuing length-1 the state goes to DRAIN.
- Valid pipeline: a MEM_LATENCY-deep shift register tags each issue with a last flag. When a tag emerges, i_mem_data and the flag are written to the FIFO.
- Output stage:
  - o_data, o_valid and o_last reflect the FIFO head (first-word fall-through).
  - o_data is held stable while o_valid=1 and i_ready=0.
- Stop: i_stop in RUN blocks further issues from the next cycle and moves the state to DRAIN. Samples already issued are still delivered in order. If the issue on the stop cycle is allowed, it proceeds.
- DRAIN->IDLE: when inflight==0 and the FIFO is empty. o_done pulses for 1 cycle on the transition cycle, and o_busy drops on the same edge.
- o_pass_count increments when the o_last sample is handshaken. It wraps modulo 2^PASS_WIDTH. A pass cut short by stop is not counted.
- Simultaneous i_start and i_stop in IDLE: start is taken; stop is ignored.
- Simultaneous push and pop on a full FIFO: both occur, and the count is unchanged.
- Sample-to-address ordering is strictly preserved. There is no reordering and no duplication.

Test Plan:
- Bench ROM model: channel c word = {c, addr}. MEM_LATENCY=1, FIFO_DEPTH=4, NUM_CH=2.
- One-shot, length=5, i_ready=1 -> first o_valid 2 cycles after the start edge. 5 consecutive samples, addr 0..4, ch1 word = {1,addr}. o_last on addr 4. o_done 1 cycle after the final handshake. o_pass_count=1.
- Loop, length=3, i_ready=1 for 12 samples -> address sequence 0,1,2,0,1,2,... with o_last every third sample. o_pass_count=4 after the 12th handshake.
- Backpressure: length=8, i_ready toggles 1,0,0,1,... -> o_data is stable during stalls. Never more than 4 samples are buffered, so issues stop when the credit is exhausted. All 8 samples arrive in order, with no loss or duplication.
- Stop mid-run: loop, length=100, i_stop pulsed at the 10th issue -> remaining in-flight samples are delivered, there are no further addresses, and o_done pulses. The pass is not counted (o_pass_count=0).
- Reset mid-operation: assert i_reset while 3 samples are in flight -> next cycle all outputs are 0. After release, no stale samples appear. A new start with length=2 produces addr 0,1 only.
- Edge cases:
  - i_start with i_length=0 -> o_busy stays 0.
  - i_start while busy -> no effect on the address sequence.
  - Rerun with MEM_LATENCY=3, FIFO_DEPTH=4 -> full-rate streaming with i_ready=1.
